mm_responder: RTL and testbench
===============================

# mm_responder

Main-memory responder for the arm9 core's line-oriented main memory port. It accepts a line request (address plus direction) on `MM_New_Line` and holds the core with `nWAIT` low for a fixed first-access latency. It then streams one word per cycle for a full cache line, returning read data on `MMD_In` or capturing write data from `MMD_Out`. It sits outside the core at the top of the system bench and backs both the icache line fills and the dcache fills and write-backs.

## Interface
Parameters:
- `WAIT_STATES`, default 2: cycles of `nWAIT` low before the first beat. Legal range 0–15.
- `LINE_WORDS`, default 8: beats per line. Must be a power of 2, range 1–16.
- `MEM_AW`, default 16: word-address bits; the array holds 2^`MEM_AW` 32-bit words.

Ports:
- `GCLK` in, 1: the single clock; all state updates on the rising edge.
- `nRESET` in, 1: asynchronous, active-low reset.
- `MMA` in, 32: line address from the core, sampled only on `MM_New_Line`.
- `MMnWR` in, 1: direction; 1 = read, 0 = write. Sampled on `MM_New_Line`.
- `MM_CE` in, 1: access enable; must stay high for the whole line.
- `MM_New_Line` in, 1: one-cycle pulse that starts a line access.
- `MMD_Out` in, 32: write data from the core.
- `MMD_In` out, 32: registered read data to the core.
- `nWAIT` out, 1: clock enable to the core; low stalls it.
- `mm_busy` out, 1: high in `LAT` and `XFER`.
- `proto_err` out, 1: sticky protocol-error flag (see Configuration).

## Operation
State machine with three states: `IDLE`, `LAT`, `XFER`.

Reset values:
- State `IDLE`; `MMD_In`=0; `nWAIT`=1; `mm_busy`=0; `proto_err`=0.
- Array contents are not reset.

`IDLE`:
- On an edge where `MM_CE` & `MM_New_Line` are both high:
  - Latch `base` = `MMA[MEM_AW+1:2]`, `dir` = `MMnWR`, and `beat` = 0.
  - If `WAIT_STATES` > 0, load the latency counter with `WAIT_STATES` and go to `LAT`.
  - Otherwise go directly to `XFER`.
- `MM_New_Line` without `MM_CE` is ignored.

`LAT`:
- `nWAIT`=0. The counter decrements each edge.
- Leave for `XFER` on the edge where the counter reaches 1.

`XFER`:
- `nWAIT`=1. One beat per cycle.
- Word address = `base[MEM_AW-1:log2 LINE_WORDS]` concatenated with (`base[log2 LINE_WORDS-1:0]` + `beat`), modulo `LINE_WORDS`. The address wraps within the line, critical word first.
- Read: `MMD_In` is registered with the beat's word on the edge that enters that beat, so it is valid for the whole beat cycle.
- Write: `MMD_Out` is written into the array at the edge ending the beat.
- After beat `LINE_WORDS`-1, return to `IDLE`.
- `MMD_In` holds its last value while idle.

Address rules:
- `MMA[1:0]` and `MMA[31:MEM_AW+2]` are ignored.
- The array aliases modulo its depth.

Boundary conditions:
- `MM_CE` falls in `LAT` or `XFER`: abort at that edge and return to `IDLE` with `nWAIT`=1. A write beat in that same edge is not performed. Beats already written remain.
- `MM_New_Line` while busy: the current line is abandoned and a new line starts, exactly as from `IDLE`. `proto_err` is set (when the macro is enabled).
- `nRESET` low mid-line: asynchronous return to reset values. The partial write stays in the array.
- `LINE_WORDS`=1: a single beat, then `IDLE`.

## Timing
- Request edge T0. `nWAIT` is low in cycles T0+1 … T0+`WAIT_STATES`.
- Beat k occupies cycle T0+`WAIT_STATES`+1+k.
- Line occupancy is `WAIT_STATES`+`LINE_WORDS` cycles.
- The earliest next `MM_New_Line` is accepted on the edge ending the last beat. That edge is itself a legal request edge, so back-to-back lines have no idle gap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
`MM_RESP_PROTOCHK_EN`:
- Defined: `proto_err` is set and held until reset by either of two events:
  - `MM_New_Line` while `mm_busy`.
  - `MM_CE` falling while `mm_busy`.
- Undefined: `proto_err` is constant 0 and the checker logic is absent.
- The data path, abort and restart behaviour are identical in both builds.

## Test plan
- Reset then idle: assert `nRESET`=0 mid-cycle, release -> `nWAIT`=1, `MMD_In`=0, `mm_busy`=0, `proto_err`=0; none of them change while `MM_CE`=0.
- Line write then read at `MMA`=0x0000_0100 with defaults: write 8 beats of 0xA0+k -> exactly 2 `nWAIT`-low cycles; the read line returns 0xA0..0xA7 on beats 0..7, and `mm_busy` is high for 10 cycles.
- Critical-word-first wrap: read at `MMA`=0x0000_0114 after the line above -> beats return 0xA5, A6, A7, A0, A1, A2, A3, A4.
- Zero latency: `WAIT_STATES`=0 -> `nWAIT` never goes low, beat 0 is in cycle T0+1, and back-to-back lines run with no gap.
- Abort: `MM_CE` drops during write beat 3 -> words 0–2 are updated, words 3–7 keep their old values, state is `IDLE` next cycle, and `proto_err`=1 only in the `MM_RESP_PROTOCHK_EN` build.
- Restart while busy: a second `MM_New_Line` at `MMA`=0x200 during `LAT` of a read to 0x100 -> the new line's latency restarts and its data comes from 0x200.

Source files
------------

// File: rtl/mm_responder.sv
// Line-oriented main-memory responder: fixed first-access latency, then one word per cycle,
// critical word first. Optional protocol checker enabled by defining MM_RESP_PROTOCHK_EN.
module mm_responder #(
    parameter int WAIT_STATES = 2,
    parameter int LINE_WORDS  = 8,
    parameter int MEM_AW      = 16
) (
    input  logic        GCLK,
    input  logic        nRESET,
    input  logic [31:0] MMA,
    input  logic        MMnWR,
    input  logic        MM_CE,
    input  logic        MM_New_Line,
    input  logic [31:0] MMD_Out,
    output logic [31:0] MMD_In,
    output logic        nWAIT,
    output logic        mm_busy,
    output logic        proto_err
);

    localparam int                BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [MEM_AW-1:0] LINE_MASK = MEM_AW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LAT, XFER} state_e;

    state_e            state_q;
    logic [MEM_AW-1:0] base_q;
    logic              dir_q;
    logic [BW-1:0]     beat_q;
    logic [3:0]        cnt_q;
    logic [31:0]       rdata_q;
    logic              nwait_q;
    logic              busy_q;

    logic [31:0]       mem [2**MEM_AW];

    logic              start;
    logic              abort;
    logic              last_beat;
    logic              do_write;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_addr;
    logic [MEM_AW-1:0] req_base;
    logic              unused_mma;

    // Word address of beat k: high bits from the line base, low bits wrap inside the line.
    function automatic logic [MEM_AW-1:0] line_addr(input logic [MEM_AW-1:0] b,
                                                    input logic [BW-1:0] k);
        return (b & ~LINE_MASK) | ((b + MEM_AW'(k)) & LINE_MASK);
    endfunction

    assign req_base   = MMA[MEM_AW+1:2];
    assign unused_mma = ^{MMA[31:MEM_AW+2], MMA[1:0]};
    assign start      = MM_CE & MM_New_Line;
    assign abort      = busy_q & ~MM_CE;
    assign last_beat  = (state_q == XFER) && (beat_q == LAST_BEAT);
    assign do_write   = (state_q == XFER) && !dir_q && MM_CE;

    // Selects the word presented in the beat that the coming edge enters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_en   = 1'b0;
        rd_addr = line_addr(base_q, beat_q + 1'b1);
        if (start) begin
            rd_en   = (WAIT_STATES == 0) && MMnWR;
            rd_addr = req_base;
        end else if (state_q == LAT) begin
            rd_en   = dir_q && (cnt_q == 4'd1);
            rd_addr = base_q;
        end else if (state_q == XFER) begin
            rd_en   = dir_q && !last_beat;
        end
    end

    always_ff @(posedge GCLK or negedge nRESET) begin
        // NOTE: sequential state is assigned with <= only, so all flops update from pre-edge values.
        if (!nRESET) begin
            state_q <= IDLE;
            base_q  <= '0;
            dir_q   <= 1'b1;
            beat_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            nwait_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (start) begin
                base_q <= req_base;
                dir_q  <= MMnWR;
                beat_q <= '0;
                busy_q <= 1'b1;
                if (WAIT_STATES > 0) begin
                    state_q <= LAT;
                    cnt_q   <= 4'(WAIT_STATES);
                    nwait_q <= 1'b0;
                end else begin
                    state_q <= XFER;
                    nwait_q <= 1'b1;
                end
            end else if (abort) begin
                state_q <= IDLE;
                nwait_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    LAT: begin
                        if (cnt_q == 4'd1) begin
                            state_q <= XFER;
                            nwait_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    XFER: begin
                        if (last_beat) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (rd_en && MM_CE) begin
                rdata_q <= mem[rd_addr];
            end
        end
    end

    // NOTE: the array has no reset; contents survive nRESET, only the control path restarts.
    always_ff @(posedge GCLK) begin
        if (do_write) begin
            mem[line_addr(base_q, beat_q)] <= MMD_Out;
        end
    end

    assign MMD_In  = rdata_q;
    assign nWAIT   = nwait_q;
    assign mm_busy = busy_q;

`ifdef MM_RESP_PROTOCHK_EN
    // A request on the edge ending the last beat is the legal back-to-back case.
    logic err_q;
    always_ff @(posedge GCLK or negedge nRESET) begin
        if (!nRESET) begin
            err_q <= 1'b0;
        end else if (busy_q && ((MM_New_Line && !last_beat) || !MM_CE)) begin
            err_q <= 1'b1;
        end
    end
    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mm_responder.sv
// Scoreboard bench for mm_responder: stimulus pushes per-cycle expectations, monitors pop
// and compare on every busy cycle of each DUT instance.
module tb_mm_responder;

    localparam int WS = 2;

`ifdef MM_RESP_PROTOCHK_EN
    localparam logic PROTO = 1'b1;
`else
    localparam logic PROTO = 1'b0;
`endif

    typedef struct {
        logic        nwait;
        logic        chk;
        logic [31:0] data;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] mma, mdo, mdi;
    logic        nwr, ce, nl, nwait, busy, perr;
    logic [31:0] mma0, mdo0, mdi0;
    logic        nwr0, ce0, nl0, nwait0, busy0, perr0;

    exp_t        q[$];
    exp_t        q0[$];
    logic [31:0] wdat [8];
    logic [31:0] rexp [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mm_responder #(.WAIT_STATES(WS), .LINE_WORDS(8), .MEM_AW(16)) dut (
        .GCLK(clk), .nRESET(nrst), .MMA(mma), .MMnWR(nwr), .MM_CE(ce),
        .MM_New_Line(nl), .MMD_Out(mdo), .MMD_In(mdi), .nWAIT(nwait),
        .mm_busy(busy), .proto_err(perr)
    );

    mm_responder #(.WAIT_STATES(0), .LINE_WORDS(4), .MEM_AW(8)) dut0 (
        .GCLK(clk), .nRESET(nrst), .MMA(mma0), .MMnWR(nwr0), .MM_CE(ce0),
        .MM_New_Line(nl0), .MMD_Out(mdo0), .MMD_In(mdi0), .nWAIT(nwait0),
        .mm_busy(busy0), .proto_err(perr0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic nw, input logic c, input logic [31:0] d, input string t);
        exp_t e;
        e.nwait = nw;
        e.chk   = c;
        e.data  = d;
        e.tag   = t;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            if (q.size() == 0) begin
                check("busy_without_expectation", 32'(busy), 32'd0);
            end else begin
                e = q.pop_front();
                check({e.tag, "_nwait"}, 32'(nwait), 32'(e.nwait));
                if (e.chk) check({e.tag, "_data"}, mdi, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("busy0_without_expectation", 32'(busy0), 32'd0);
            end else begin
                e = q0.pop_front();
                check({e.tag, "_nwait"}, 32'(nwait0), 32'(e.nwait));
                if (e.chk) check({e.tag, "_data"}, mdi0, e.data);
            end
        end
    end

    // One line on the main instance; last_beat < 7 drops MM_CE during that beat.
    task automatic line(input logic [31:0] addr, input logic rd, input string tag, input int last_beat);
        for (int i = 0; i < WS; i++) q.push_back(mk(1'b0, 1'b0, 32'h0, tag));
        for (int k = 0; k <= last_beat; k++) q.push_back(mk(1'b1, rd, rexp[k], tag));
        mma = addr; nwr = rd; ce = 1'b1; nl = 1'b1;
        @(posedge clk); #1;
        nl = 1'b0;
        repeat (WS) begin @(posedge clk); #1; end
        for (int k = 0; k <= last_beat; k++) begin
            mdo = wdat[k];
            if (k == last_beat && last_beat < 7) ce = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_nwait"}, 32'(nwait), 32'd1);
        ce = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b1;
        mma = '0; nwr = 1'b1; ce = 1'b0; nl = 1'b0; mdo = '0;
        mma0 = '0; nwr0 = 1'b1; ce0 = 1'b0; nl0 = 1'b0; mdo0 = '0;
        for (int k = 0; k < 8; k++) begin wdat[k] = '0; rexp[k] = '0; end

        // Reset mid-cycle, then idle stability with MM_CE low.
        #2 nrst = 1'b0;
        #1;
        check("rst_nwait", 32'(nwait), 32'd1);
        check("rst_mmd_in", mdi, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_proto_err", 32'(perr), 32'd0);
        check("rst0_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mma = 32'h0000_0100 + 32'(i * 4); nwr = i[0]; nl = 1'b1; ce = 1'b0;
            @(posedge clk); #1;
            check("idle_nwait", 32'(nwait), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_mmd_in", mdi, 32'd0);
            check("idle_proto_err", 32'(perr), 32'd0);
        end
        nl = 1'b0;

        // Write then read a full line at 0x100.
        for (int k = 0; k < 8; k++) wdat[k] = 32'hA0 + 32'(k);
        line(32'h0000_0100, 1'b0, "wr_a", 7);
        rexp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        line(32'h0000_0100, 1'b1, "rd_a", 7);
        check("rd_a_proto_err", 32'(perr), 32'd0);

        // Critical word first.
        rexp = '{32'hA5, 32'hA6, 32'hA7, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        line(32'h0000_0114, 1'b1, "wrap", 7);

        // Abort during write beat 3.
        for (int k = 0; k < 8; k++) wdat[k] = 32'hB0 + 32'(k);
        line(32'h0000_0100, 1'b0, "abort", 3);
        check("abort_proto_err", 32'(perr), 32'(PROTO));
        rexp = '{32'hB0, 32'hB1, 32'hB2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        line(32'h0000_0100, 1'b1, "abort_rd", 7);

        // Reset asserted during write beat 2 of line 0x300.
        for (int k = 0; k < 8; k++) wdat[k] = 32'hE0 + 32'(k);
        line(32'h0000_0300, 1'b0, "wr_e", 7);
        for (int i = 0; i < WS; i++) q.push_back(mk(1'b0, 1'b0, 32'h0, "rstline"));
        for (int k = 0; k < 2; k++) q.push_back(mk(1'b1, 1'b0, 32'h0, "rstline"));
        mma = 32'h0000_0300; nwr = 1'b0; ce = 1'b1; nl = 1'b1;
        @(posedge clk); #1;
        nl = 1'b0;
        repeat (WS) begin @(posedge clk); #1; end
        for (int k = 0; k < 2; k++) begin
            mdo = 32'hD0 + 32'(k);
            @(posedge clk); #1;
        end
        mdo = 32'hD2;
        #2 nrst = 1'b0;
        #1;
        check("midrst_nwait", 32'(nwait), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mmd_in", mdi, 32'd0);
        check("midrst_proto_err", 32'(perr), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        rexp = '{32'hD0, 32'hD1, 32'hE2, 32'hE3, 32'hE4, 32'hE5, 32'hE6, 32'hE7};
        line(32'h0000_0300, 1'b1, "midrst_rd", 7);

        // Restart: read 0x100 abandoned in its latency by a request for 0x200.
        for (int k = 0; k < 8; k++) wdat[k] = 32'hC0 + 32'(k);
        line(32'h0000_0200, 1'b0, "wr_c", 7);
        check("wr_c_proto_err", 32'(perr), 32'd0);
        q.push_back(mk(1'b0, 1'b0, 32'h0, "restart_old"));
        for (int i = 0; i < WS; i++) q.push_back(mk(1'b0, 1'b0, 32'h0, "restart_lat"));
        for (int k = 0; k < 8; k++) q.push_back(mk(1'b1, 1'b1, 32'hC0 + 32'(k), "restart"));
        mma = 32'h0000_0100; nwr = 1'b1; ce = 1'b1; nl = 1'b1;
        @(posedge clk); #1;
        mma = 32'h0000_0200;
        @(posedge clk); #1;
        nl = 1'b0;
        repeat (WS + 8) begin @(posedge clk); #1; end
        check("restart_idle_busy", 32'(busy), 32'd0);
        check("restart_proto_err", 32'(perr), 32'(PROTO));

        // Zero latency, back-to-back writes on the second instance.
        for (int k = 0; k < 8; k++) q0.push_back(mk(1'b1, 1'b0, 32'h0, "b2b_wr"));
        mma0 = 32'h0000_0000; nwr0 = 1'b0; ce0 = 1'b1; nl0 = 1'b1;
        @(posedge clk); #1;
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < 4; k++) begin
                mdo0 = (ln == 0 ? 32'h10 : 32'h20) + 32'(k);
                nl0  = (ln == 0 && k == 3);
                if (nl0) mma0 = 32'h0000_0010;
                @(posedge clk); #1;
            end
        end
        check("b2b_wr_idle_busy", 32'(busy0), 32'd0);

        // Back-to-back reads: aliased, misaligned address, then a wrapped second line.
        rexp = '{32'h12, 32'h13, 32'h10, 32'h11, 32'h21, 32'h22, 32'h23, 32'h20};
        for (int k = 0; k < 8; k++) q0.push_back(mk(1'b1, 1'b1, rexp[k], "b2b_rd"));
        mma0 = 32'hFFFF_FC0B; nwr0 = 1'b1; nl0 = 1'b1;
        @(posedge clk); #1;
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < 4; k++) begin
                nl0 = (ln == 0 && k == 3);
                if (nl0) mma0 = 32'h0000_0014;
                @(posedge clk); #1;
            end
        end
        check("b2b_rd_idle_busy", 32'(busy0), 32'd0);
        check("b2b_proto_err", 32'(perr0), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        check("scoreboard0_drained", 32'(q0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
